// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to a keyboard:
// inhibits the clock line, drives the start bit, shifts the data bits, the
// odd-parity bit and the stop bit on the device's falling clock edges,
// samples the device ACK on the 11th falling edge, then waits for the bus to
// go idle before reporting completion. Timeouts abort the frame.
//
// Ports
//   clk          system clock, all state on the rising edge
//   resetn       asynchronous active-low reset
//   ps2_clk_i    raw PS/2 clock line level (asynchronous)
//   ps2_data_i   raw PS/2 data line level (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe  1 = pull PS/2 data low, 0 = release
//   tx_data      command byte to send
//   tx_valid     request to send tx_data
//   tx_ready     block idle and accepting a request
//   done         one-cycle pulse when a frame completes
//   ack_ok       valid with done: 1 = device ACK seen, 0 = NACK
//   error        one-cycle pulse on timeout abort
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int CLK_HZ           = 25000000,
    parameter int INHIBIT_US       = 100,
    parameter int START_TIMEOUT_US = 15000,
    parameter int FRAME_TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    localparam int CYC_PER_US  = CLK_HZ / 1000000;
    localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
    localparam int START_CYC   = CYC_PER_US * START_TIMEOUT_US;
    localparam int FRAME_CYC   = CYC_PER_US * FRAME_TIMEOUT_US;
    localparam int MAX_AB      = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
    localparam int MAX_CYC     = (MAX_AB > FRAME_CYC) ? MAX_AB : FRAME_CYC;
    // Sized so the longest interval loads without truncation and counts
    // down to zero without wrapping.
    localparam int TW          = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] INHIBIT_LOAD = TW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] START_LOAD   = TW'(START_CYC - 1);
    localparam logic [TW-1:0] FRAME_LOAD   = TW'(FRAME_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Line synchronizers; r_clk_prev holds the previous synced clock level.
    logic            r_clk_meta;
    logic            r_clk_sync;
    logic            r_clk_prev;
    logic            r_data_meta;
    logic            r_data_sync;

    logic [7:0]      r_data;
    logic            r_parity;
    logic [3:0]      r_bit_cnt;
    logic [TW-1:0]   r_timer;
    logic            r_ack;
    logic            r_clk_oe;
    logic            r_data_oe;
    logic            r_done;
    logic            r_ack_ok;
    logic            r_error;

    logic [7:0]      w_data_nxt;
    logic            w_parity_nxt;
    logic [3:0]      w_bit_cnt_nxt;
    logic [TW-1:0]   w_timer_nxt;
    logic            w_ack_nxt;
    logic            w_clk_oe_nxt;
    logic            w_data_oe_nxt;
    logic            w_done_nxt;
    logic            w_ack_ok_nxt;
    logic            w_error_nxt;

    logic            w_fall;
    logic            w_timer_zero;

    assign w_fall       = r_clk_prev & ~r_clk_sync;
    assign w_timer_zero = (r_timer == '0);

    // NOTE: every signal gets its default before the case statement, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_data_nxt    = r_data;
        w_parity_nxt  = r_parity;
        w_bit_cnt_nxt = r_bit_cnt;
        w_timer_nxt   = r_timer;
        w_ack_nxt     = r_ack;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        w_ack_ok_nxt  = 1'b0;
        w_error_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_data_nxt    = tx_data;
                    w_parity_nxt  = ~^tx_data;
                    w_bit_cnt_nxt = '0;
                    w_timer_nxt   = INHIBIT_LOAD;
                    w_clk_oe_nxt  = 1'b1;
                    w_state_nxt   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                w_clk_oe_nxt = 1'b1;
                if (w_timer_zero) begin
                    w_data_oe_nxt = 1'b1;
                    w_state_nxt   = S_START;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end

            // Clock released while data stays low: this is the start bit.
            S_START: begin
                w_data_oe_nxt = 1'b1;
                w_timer_nxt   = START_LOAD;
                w_state_nxt   = S_SEND;
            end

            // Before fall 1 the timer guards the device's start; from fall 1
            // on it is reloaded and guards the whole remaining frame.
            S_SEND: begin
                w_data_oe_nxt = r_data_oe;
                if (w_timer_zero && !(w_fall && r_bit_cnt == 4'd0)) begin
                    w_data_oe_nxt = 1'b0;
                    w_error_nxt   = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                    if (w_fall) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd0) begin
                            w_timer_nxt = FRAME_LOAD;
                        end
                        if (r_bit_cnt < 4'd8) begin
                            w_data_oe_nxt = ~r_data[r_bit_cnt[2:0]];
                        end else if (r_bit_cnt == 4'd8) begin
                            w_data_oe_nxt = ~r_parity;
                        end else begin
                            w_data_oe_nxt = 1'b0;
                            w_state_nxt   = S_ACK;
                        end
                    end
                end
            end

            S_ACK: begin
                if (w_timer_zero) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                    if (w_fall) begin
                        w_ack_nxt   = ~r_data_sync;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                if (r_clk_sync && r_data_sync) begin
                    w_done_nxt   = 1'b1;
                    w_ack_ok_nxt = r_ack;
                    w_state_nxt  = S_IDLE;
                end else if (w_timer_zero) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
            r_data      <= '0;
            r_parity    <= 1'b0;
            r_bit_cnt   <= '0;
            r_timer     <= '0;
            r_ack       <= 1'b0;
            r_clk_oe    <= 1'b0;
            r_data_oe   <= 1'b0;
            r_done      <= 1'b0;
            r_ack_ok    <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_clk_meta  <= ps2_clk_i;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data_i;
            r_data_sync <= r_data_meta;
            r_state     <= w_state_nxt;
            r_data      <= w_data_nxt;
            r_parity    <= w_parity_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_timer     <= w_timer_nxt;
            r_ack       <= w_ack_nxt;
            r_clk_oe    <= w_clk_oe_nxt;
            r_data_oe   <= w_data_oe_nxt;
            r_done      <= w_done_nxt;
            r_ack_ok    <= w_ack_ok_nxt;
            r_error     <= w_error_nxt;
        end
    end

    // Line drives are registered, so the async reset releases them at once.
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_ready    = (r_state == S_IDLE);
    assign done        = r_done;
    assign ack_ok      = r_ack_ok;
    assign error       = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx. A small device model answers on a
// wired-AND bus; expected frame bits are hand-computed constants laid out as
// {stop, parity, data[7:0]} in the order the device samples them.
// Timeouts are shortened so every scenario fits a short run.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int CLK_HZ      = 25000000;
    localparam int INHIBIT_US  = 100;
    localparam int START_US    = 100;
    localparam int FRAME_US    = 40;
    localparam int INHIBIT_CYC = 2500;
    localparam int START_CYC   = 2500;
    localparam int HALF        = 20;

    logic       clk      = 1'b0;
    logic       resetn   = 1'b0;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;

    logic ps2_clk_oe, ps2_data_oe, tx_ready, done, ack_ok, error;
    logic ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .CLK_HZ          (CLK_HZ),
        .INHIBIT_US      (INHIBIT_US),
        .START_TIMEOUT_US(START_US),
        .FRAME_TIMEOUT_US(FRAME_US)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk_i  (ps2_clk_line),
        .ps2_data_i (ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .done       (done),
        .ack_ok     (ack_ok),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output pulse monitor, sampled on the falling edge.
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         done_cyc = 0;
    int         err_cyc  = 0;
    logic       last_ack = 1'b0;
    logic [1:0] err_oe   = 2'b00;

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            last_ack <= ack_ok;
        end
        if (error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
            err_oe  <= {ps2_clk_oe, ps2_data_oe};
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int send_cyc = 0;
    int inh_cyc  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic request(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
    endtask

    // Follows inhibit/start/start-bit phases; ends on the first SEND cycle.
    task automatic watch_inhibit(input string tag, input bit keep_valid);
        int n;
        n = 0;
        while (!ps2_clk_oe && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 32'(ps2_clk_oe), 32'd1);
        inh_cyc = cyc;
        if (!keep_valid) tx_valid = 1'b0;
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 10000) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_inhibit_len"}, 32'(n), 32'(INHIBIT_CYC));
        check({tag, "_start_lines"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'b11);
        @(negedge clk);
        check({tag, "_startbit_lines"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
        send_cyc = cyc;
    endtask

    // Device model: clocks nfalls falling edges, samples the data line three
    // cycles after each of falls 1..10 and optionally ACKs on fall 11.
    // With nfalls < 11 it returns holding the clock low after the last fall.
    task automatic dev_frame(input int nfalls, input bit give_ack, output logic [9:0] bits);
        bits = '0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < nfalls; i++) begin
            if (i == 10 && give_ack) begin
                dev_data = 1'b0;
                repeat (HALF / 2) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (3) @(negedge clk);
            if (i < 10) bits[i] = ps2_data_line;
            if (i == nfalls - 1 && nfalls < 11) return;
            repeat (HALF - 3) @(negedge clk);
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    // Bounded wait for the next done pulse; ends on a falling edge.
    task automatic wait_done(input string tag, input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < 500) begin
            @(posedge clk);
            n++;
        end
        check(tag, 32'(done_cnt), 32'(base + 1));
        @(negedge clk);
    endtask

    task automatic full_frame(input string tag, input logic [7:0] b, input bit give_ack,
                              input logic [9:0] exp_bits, input bit keep_valid);
        logic [9:0] bits;
        int         base;
        base = done_cnt;
        request(b);
        watch_inhibit(tag, keep_valid);
        dev_frame(11, give_ack, bits);
        check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        wait_done({tag, "_done"}, base);
        check({tag, "_ack_ok"}, 32'(last_ack), 32'(give_ack));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] bits;
        int         base_done;
        int         base_err;
        int         n;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({ps2_clk_oe, ps2_data_oe, done, ack_ok, error}), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);

        // 0xED with ACK: data 1,0,1,1,0,1,1,1, parity 1, stop 1
        full_frame("ed", 8'hED, 1'b1, 10'h3ED, 1'b0);

        // 0x00 with NACK: parity 1, stop 1
        full_frame("zero", 8'h00, 1'b0, 10'h300, 1'b0);
        check("no_error_so_far", 32'(err_cnt), 32'd0);

        // Device never clocks: start timeout
        base_done = done_cnt;
        base_err  = err_cnt;
        request(8'h5A);
        watch_inhibit("to", 1'b0);
        n = 0;
        while (err_cnt == base_err && n < START_CYC + 500) begin
            @(posedge clk);
            n++;
        end
        check("to_error_seen", 32'(err_cnt), 32'(base_err + 1));
        check("to_error_latency", 32'(err_cyc - send_cyc), 32'(START_CYC));
        check("to_error_lines", 32'(err_oe), 32'd0);
        @(negedge clk);
        check("to_tx_ready", 32'(tx_ready), 32'd1);
        repeat (5) @(negedge clk);
        check("to_single_pulse", 32'(err_cnt), 32'(base_err + 1));
        check("to_no_done", 32'(done_cnt), 32'(base_done));

        // Reset after fall 4 of 0x55 (bit 3 = 0, so data is being pulled low)
        base_done = done_cnt;
        base_err  = err_cnt;
        request(8'h55);
        watch_inhibit("rst", 1'b0);
        dev_frame(4, 1'b0, bits);
        check("rst_bits_before", 32'(bits[3:0]), 32'h5);
        check("rst_data_driven", 32'(ps2_data_oe), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        repeat (2) @(negedge clk);
        dev_clk = 1'b1;
        resetn  = 1'b1;
        @(negedge clk);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        repeat (5) @(negedge clk);
        check("rst_no_done", 32'(done_cnt), 32'(base_done));
        check("rst_no_error", 32'(err_cnt), 32'(base_err));
        full_frame("post_rst", 8'h01, 1'b1, 10'h201, 1'b0);

        // tx_valid held with tx_data changing mid-frame
        request(8'hA5);
        watch_inhibit("hold1", 1'b1);
        tx_data = 8'h3D;
        base_done = done_cnt;
        dev_frame(11, 1'b1, bits);
        check("hold1_bits", 32'(bits), 32'h3A5);
        wait_done("hold1_done", base_done);
        check("hold1_ack_ok", 32'(last_ack), 32'd1);
        base_done = done_cnt;
        watch_inhibit("hold2", 1'b0);
        check("hold2_accept_cycle", 32'(inh_cyc), 32'(done_cyc + 1));
        dev_frame(11, 1'b1, bits);
        check("hold2_bits", 32'(bits), 32'h23D);
        wait_done("hold2_done", base_done);
        check("hold2_ack_ok", 32'(last_ack), 32'd1);
        repeat (10) @(negedge clk);
        check("final_tx_ready", 32'(tx_ready), 32'd1);
        check("final_error_count", 32'(err_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, system clock frequency in Hz.
REQ-002 SHALL have parameter INHIBIT_US, default 100, clock-inhibit time before the start bit.
REQ-003 SHALL have parameter START_TIMEOUT_US, default 15000, maximum wait for the first device falling edge.
REQ-004 SHALL have parameter FRAME_TIMEOUT_US, default 2000, maximum time from first falling edge to ACK.
REQ-005 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-006 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port ps2_clk_i  input  1  raw PS/2 clock line level, asynchronous.
REQ-008 SHALL have port ps2_data_i  input  1  raw PS/2 data line level, asynchronous.
REQ-009 SHALL have port ps2_clk_oe  output  1  1 = drive PS/2 clock low, 0 = release.
REQ-010 SHALL have port ps2_data_oe  output  1  1 = drive PS/2 data low, 0 = release.
REQ-011 SHALL have port tx_data  input  8  command byte to send to the keyboard.
REQ-012 SHALL have port tx_valid  input  1  request to send tx_data.
REQ-013 SHALL have port tx_ready  output  1  block idle, accepting a request.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a frame completes.
REQ-015 SHALL have port ack_ok  output  1  valid with done; 1 = device ACK seen, 0 = NACK.
REQ-016 SHALL have port error  output  1  one-cycle pulse on timeout abort.

Function
REQ-017 SHALL pass ps2_clk_i and ps2_data_i through 2-flop synchronizers; fall = previous synced clk 1 and current synced clk 0.
REQ-018 SHALL implement states IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE.
REQ-019 SHALL drive tx_ready = 1 only in IDLE and accept a byte on the clk edge where tx_valid && tx_ready, latching tx_data and odd parity (~^tx_data).
REQ-020 SHALL ignore tx_valid outside IDLE.
REQ-021 SHALL, in INHIBIT, assert ps2_clk_oe=1, ps2_data_oe=0 for exactly CLK_HZ/1000000*INHIBIT_US cycles (2500 at defaults), starting the cycle after acceptance.
REQ-022 SHALL, in START, assert ps2_clk_oe=1, ps2_data_oe=1 for exactly one cycle, then enter SEND with ps2_clk_oe=0 and ps2_data_oe still 1 (start bit).
REQ-023 SHALL, in SEND, on falls 1..8 set ps2_data_oe = ~bit of data bits 0..7 (LSB first), on fall 9 set ~parity, on fall 10 set 0 (stop, released), then enter ACK.
REQ-024 SHALL update ps2_data_oe no later than 3 clk cycles after the raw ps2_clk_i falling edge.
REQ-025 SHALL, in ACK, on fall 11 capture ack = (synced data == 0) and enter WAIT_IDLE.
REQ-026 SHALL, in WAIT_IDLE, wait until synced clk and data are both 1, then pulse done=1 with ack_ok=ack for one cycle and return to IDLE.
REQ-027 SHALL abort with a one-cycle error pulse if fall 1 does not occur within CLK_HZ/1000000*START_TIMEOUT_US cycles of entering SEND, or if the state is not IDLE within CLK_HZ/1000000*FRAME_TIMEOUT_US cycles after fall 1.
REQ-028 SHALL, on abort, release both lines in the same cycle as the error pulse, not pulse done, and return to IDLE.
REQ-029 SHALL use timer and bit counters wide enough for START_TIMEOUT_US at CLK_HZ with no wrap before expiry.
REQ-030 SHALL hold both oe outputs at 0 in IDLE, WAIT_IDLE and after the stop bit.

Reset
REQ-031 SHALL, while resetn=0, force state IDLE, ps2_clk_oe=0, ps2_data_oe=0, done=0, ack_ok=0, error=0, and clear all counters and synchronizers to 1 (line idle).
REQ-032 SHALL release both lines immediately (asynchronously) on reset assertion mid-frame, and show tx_ready=1 on the first cycle after deassertion.

Verification
REQ-033 SHALL verify: send 0xED, device model clocks and ACKs -> inhibit 2500 cycles, data line after falls 1..10 = 1,0,1,1,0,1,1,1,parity 1,stop 1; done=1, ack_ok=1.
REQ-034 SHALL verify: send 0x00, device leaves data high at fall 11 -> parity bit 1; done=1, ack_ok=0.
REQ-035 SHALL verify: device never clocks -> error pulse exactly START_TIMEOUT cycles after SEND entry; both oe=0; tx_ready=1 next cycle.
REQ-036 SHALL verify: resetn low after fall 4 -> both oe=0 within the same cycle; no done or error pulse; next request sends a complete, correct frame.
REQ-037 SHALL verify: tx_valid held high with changing tx_data during a frame -> only the first byte is sent; the next byte is accepted in the cycle after done.
